// File: rtl/uart_pkg.sv
// Shared UART constants and state encodings for the relay and its sniffer tap.
package uart_pkg;

  // Source tags sent ahead of each captured byte ('1' = board 1, '2' = board 2)
  localparam logic [7:0] TAG_B1 = 8'h31;
  localparam logic [7:0] TAG_B2 = 8'h32;

  // 8N1 frame layout: start, eight data bits LSB first, stop
  localparam int         FRAME_BITS    = 10;
  localparam int         DATA_BITS     = 8;
  localparam int         START_BIT_IDX = 0;
  localparam int         STOP_BIT_IDX  = 9;
  localparam logic [2:0] LAST_DATA_IDX = 3'd7;

  // Sequencer: tag frame followed by data frame for every popped entry
  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_TAG  = 2'd1,
    SEQ_DATA = 2'd2
  } seq_state_t;

  // Serializer frame phases
  typedef enum logic [1:0] {
    SER_READY = 2'd0,
    SER_START = 2'd1,
    SER_BITS  = 2'd2,
    SER_STOP  = 2'd3
  } ser_state_t;

  // Tag byte for a captured entry's source bit
  function automatic logic [7:0] src_tag(input logic src);
    return src ? TAG_B2 : TAG_B1;
  endfunction

endpackage

// File: rtl/uart_tap_ser.sv
// 8N1 serializer. Handshake: a frame is accepted on any edge where load and
// ready are both high; ready is high while idle and during the final cycle of
// a stop bit, so a load there starts the next frame with no idle gap. The
// line output is registered, so it trails the frame state by one cycle.
module uart_tap_ser
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       dout
);

  localparam int             CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  ser_state_t    state, state_next;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic          baud_last;
  logic          accept;

  assign baud_last = (baud_cnt == BAUD_LAST);
  assign ready     = (state == SER_READY) || ((state == SER_STOP) && baud_last);
  assign accept    = load && ready;

  // Frame phase sequencing: start, eight data bits, stop, then next frame or idle
  always_comb begin
    state_next = state;
    case (state)
      SER_READY: if (load) state_next = SER_START;
      SER_START: if (baud_last) state_next = SER_BITS;
      SER_BITS:  if (baud_last && (bit_idx == LAST_DATA_IDX)) state_next = SER_STOP;
      SER_STOP:  if (baud_last) state_next = load ? SER_START : SER_READY;
      default:   state_next = SER_READY;
    endcase
  end

  // Baud/bit counters, shift register and registered line driver
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SER_READY;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      dout      <= 1'b1;
    end else begin
      state <= state_next;
      if (accept) begin
        baud_cnt  <= '0;
        shift_reg <= data;
      end else begin
        if (state != SER_READY) baud_cnt <= baud_last ? '0 : baud_cnt + CW'(1);
        if ((state == SER_BITS) && baud_last) shift_reg <= {1'b0, shift_reg[7:1]};
      end
      if (state == SER_START) bit_idx <= '0;
      else if ((state == SER_BITS) && baud_last) bit_idx <= bit_idx + 3'd1;
      dout <= (state == SER_START) ? 1'b0 :
              (state == SER_BITS)  ? shift_reg[0] : 1'b1;
    end
  end

endmodule

// File: rtl/uart_tap_tx.sv
// Sniffer return path: captures bytes from both boards, tags them with their
// source, queues them and sends tag+data frame pairs to the PC.
module uart_tap_tx
  import uart_pkg::*;
#(
  parameter int SYSTEM_CLOCK = 32000000,
  parameter int BAUD_RATE    = 9600,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic                            b1_valid,
  input  logic [7:0]                      b1_data,
  input  logic                            b2_valid,
  input  logic [7:0]                      b2_data,
  input  logic                            clear_drops,
  output logic                            pc_tx_bus,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic [7:0]                      drop_count
);

  localparam int CLKS_PER_BIT = SYSTEM_CLOCK / BAUD_RATE;
  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam int LW           = $clog2(FIFO_DEPTH + 1);

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [8:0]    rd_data;
  logic          full, empty;

  logic          b1_cap, b2_cap;
  logic          pend_valid;
  logic [8:0]    pend_data;
  logic          wr_en, pend_set, lost;
  logic [8:0]    wr_data, pend_next;
  logic          push, pop, drop_fifo;
  logic [1:0]    n_drop;
  logic [8:0]    drop_sum;

  seq_state_t    seq_state, seq_next;
  logic [7:0]    data_hold;
  logic          ser_load, ser_ready;
  logic [7:0]    ser_data;

  assign b1_cap  = enable && b1_valid;
  assign b2_cap  = enable && b2_valid;
  assign full    = (fifo_level == LW'(FIFO_DEPTH));
  assign empty   = (fifo_level == '0);
  assign rd_data = mem[rd_ptr];

  // Write arbitration: a pending entry goes first; a colliding capture is
  // deferred into the pending slot. With the slot already busy and both boards
  // firing, only one can be deferred and the board-2 byte is lost.
  always_comb begin
    wr_en     = 1'b0;
    wr_data   = '0;
    pend_set  = 1'b0;
    pend_next = '0;
    lost      = 1'b0;
    if (pend_valid) begin
      wr_en   = 1'b1;
      wr_data = pend_data;
      if (b1_cap) begin
        pend_set  = 1'b1;
        pend_next = {1'b0, b1_data};
        lost      = b2_cap;
      end else if (b2_cap) begin
        pend_set  = 1'b1;
        pend_next = {1'b1, b2_data};
      end
    end else if (b1_cap) begin
      wr_en   = 1'b1;
      wr_data = {1'b0, b1_data};
      if (b2_cap) begin
        pend_set  = 1'b1;
        pend_next = {1'b1, b2_data};
      end
    end else if (b2_cap) begin
      wr_en   = 1'b1;
      wr_data = {1'b1, b2_data};
    end
  end

  // A full FIFO still accepts a write when the same cycle pops
  assign push      = wr_en && (!full || pop);
  assign drop_fifo = wr_en && !push;
  assign n_drop    = {1'b0, drop_fifo} + {1'b0, lost};
  assign drop_sum  = {1'b0, drop_count} + {7'd0, n_drop};

  // Pending slot for the deferred half of a collision
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_valid <= 1'b0;
      pend_data  <= '0;
    end else begin
      pend_valid <= pend_set;
      if (pend_set) pend_data <= pend_next;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Saturating drop counter; a clear wins over a same-cycle drop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             drop_count <= '0;
    else if (clear_drops) drop_count <= '0;
    else if (n_drop != 2'd0) drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  // Sequencer next state: pop and send tag, then the held data byte
  always_comb begin
    seq_next = seq_state;
    pop      = 1'b0;
    ser_load = 1'b0;
    ser_data = '0;
    case (seq_state)
      SEQ_IDLE: if (!empty && ser_ready) begin
        pop      = 1'b1;
        ser_load = 1'b1;
        ser_data = src_tag(rd_data[8]);
        seq_next = SEQ_TAG;
      end
      SEQ_TAG: if (ser_ready) begin
        ser_load = 1'b1;
        ser_data = data_hold;
        seq_next = SEQ_DATA;
      end
      SEQ_DATA: if (ser_ready) begin
        if (!empty) begin
          pop      = 1'b1;
          ser_load = 1'b1;
          ser_data = src_tag(rd_data[8]);
          seq_next = SEQ_TAG;
        end else begin
          seq_next = SEQ_IDLE;
        end
      end
      default: seq_next = SEQ_IDLE;
    endcase
  end

  // Sequencer state, held data byte and busy aligned with the line output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seq_state <= SEQ_IDLE;
      data_hold <= '0;
      busy      <= 1'b0;
    end else begin
      seq_state <= seq_next;
      if (pop) data_hold <= rd_data[7:0];
      busy <= (seq_state != SEQ_IDLE);
    end
  end

  uart_tap_ser #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk  (clk),
    .rst  (rst),
    .load (ser_load),
    .data (ser_data),
    .ready(ser_ready),
    .dout (pc_tx_bus)
  );

endmodule

// File: tb/tb_uart_tap_tx.sv
// Directed bench for uart_tap_tx with a line decoder feeding a byte queue.
module tb_uart_tap_tx;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       rst;
  logic       enable;
  logic       b1_valid;
  logic [7:0] b1_data;
  logic       b2_valid;
  logic [7:0] b2_data;
  logic       clear_drops;
  logic       pc_tx_bus;
  logic       busy;
  logic [2:0] fifo_level;
  logic [7:0] drop_count;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tap_tx #(
    .SYSTEM_CLOCK(16),
    .BAUD_RATE   (1),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .b1_valid   (b1_valid),
    .b1_data    (b1_data),
    .b2_valid   (b2_valid),
    .b2_data    (b2_data),
    .clear_drops(clear_drops),
    .pc_tx_bus  (pc_tx_bus),
    .busy       (busy),
    .fifo_level (fifo_level),
    .drop_count (drop_count)
  );

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  logic       rx_on = 1'b0;
  logic       track_lvl = 1'b0;
  int         max_lvl = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pair(input logic [7:0] tag_b, input logic [7:0] dat);
    exp_q.push_back({1'b1, tag_b});
    exp_q.push_back({1'b1, dat});
  endtask

  // Wait (bounded) for n decoded frames and compare them with the expected queue
  task automatic wait_rx(input int n, input string tag);
    int waited = 0;
    logic [8:0] g, e;
    while (got_q.size() < n && waited < 4000) begin
      tick();
      waited++;
    end
    check({tag, "_count"}, got_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (got_q.size() == 0 || exp_q.size() == 0) break;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check(tag, {23'd0, g}, {23'd0, e});
    end
  endtask

  // Line decoder: mid-bit sampling on the falling clock edge; stop bit kept as bit 8
  initial begin
    logic [7:0] b;
    logic       stp;
    forever begin
      @(negedge clk);
      if (rx_on && rst && pc_tx_bus === 1'b0) begin
        repeat (8) @(negedge clk);
        b = '0;
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(negedge clk);
          b[i] = pc_tx_bus;
        end
        repeat (16) @(negedge clk);
        stp = pc_tx_bus;
        if (rx_on) got_q.push_back({stp, b});
      end
    end
  end

  // Peak occupancy monitor
  always @(negedge clk) begin
    if (track_lvl && int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
  end

  // Watchdog
  initial begin
    #(20000 * 10);
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [19:0] pat;
    int wave_err, busy_err, low_cnt;

    rst = 1'b1; enable = 1'b0; b1_valid = 1'b0; b1_data = '0;
    b2_valid = 1'b0; b2_data = '0; clear_drops = 1'b0;
    #3 rst = 1'b0;
    repeat (3) tick();
    check("rst_line", pc_tx_bus, 1);
    check("rst_busy", busy, 0);
    check("rst_level", fifo_level, 0);
    check("rst_drops", drop_count, 0);
    rst = 1'b1;
    rx_on = 1'b1;
    enable = 1'b1;
    repeat (2) tick();

    // Test 1: single byte, exact waveform and latency
    b1_valid = 1'b1; b1_data = 8'hA5;
    tick();                                  // edge t
    b1_valid = 1'b0;
    check("t1_level_t", fifo_level, 1);
    check("t1_line_t", pc_tx_bus, 1);
    tick();                                  // edge t+1
    check("t1_level_t1", fifo_level, 0);
    check("t1_line_t1", pc_tx_bus, 1);
    tick();                                  // edge t+2
    pat = {1'b1, 8'hA5, 1'b0, 1'b1, 8'h31, 1'b0};
    wave_err = 0; busy_err = 0;
    for (int k = 0; k < 320; k++) begin
      if (pc_tx_bus !== pat[k/16]) wave_err++;
      if (busy !== 1'b1) busy_err++;
      tick();
    end
    check("t1_wave", wave_err, 0);
    check("t1_busy", busy_err, 0);
    check("t1_line_end", pc_tx_bus, 1);
    check("t1_busy_end", busy, 0);
    expect_pair(8'h31, 8'hA5);
    wait_rx(2, "t1_rx");

    // Test 2: simultaneous board 1 and board 2 capture
    repeat (20) tick();
    max_lvl = 0; track_lvl = 1'b1;
    b1_valid = 1'b1; b1_data = 8'h11; b2_valid = 1'b1; b2_data = 8'h22;
    tick();
    b1_valid = 1'b0; b2_valid = 1'b0;
    check("t2_level_t", fifo_level, 1);
    tick();
    check("t2_level_t1", fifo_level, 1);
    expect_pair(8'h31, 8'h11);
    expect_pair(8'h32, 8'h22);
    wait_rx(4, "t2_rx");
    track_lvl = 1'b0;
    check("t2_peak", max_lvl, 1);
    repeat (20) tick();

    // Test 4: capture disabled
    enable = 1'b0;
    b2_valid = 1'b1; b2_data = 8'h7E;
    tick();
    b2_valid = 1'b0;
    check("t4_level", fifo_level, 0);
    check("t4_drops", drop_count, 0);
    low_cnt = 0;
    for (int k = 0; k < 50; k++) begin
      if (pc_tx_bus !== 1'b1) low_cnt++;
      tick();
    end
    check("t4_line_idle", low_cnt, 0);
    check("t4_busy", busy, 0);
    enable = 1'b1;

    // Test 3: six back-to-back bytes into a depth-4 FIFO
    for (int i = 1; i <= 6; i++) begin
      b1_valid = 1'b1; b1_data = 8'(i);
      tick();
    end
    b1_valid = 1'b0;
    check("t3_level", fifo_level, 4);
    check("t3_drops", drop_count, 1);
    for (int i = 1; i <= 5; i++) expect_pair(8'h31, 8'(i));
    wait_rx(10, "t3_rx");
    repeat (20) tick();
    check("t3_level_end", fifo_level, 0);
    check("t3_drops_end", drop_count, 1);

    // Test 5: reset during a data bit of the A5 frame
    b1_valid = 1'b1; b1_data = 8'hA5;
    tick();                                  // edge t
    b1_valid = 1'b0;
    repeat (231) tick();                     // inside data bit 3 of the second frame
    check("t5_busy_pre", busy, 1);
    rx_on = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("t5_line", pc_tx_bus, 1);
    check("t5_busy", busy, 0);
    check("t5_level", fifo_level, 0);
    check("t5_drops", drop_count, 0);
    repeat (3) tick();
    rst = 1'b1;
    low_cnt = 0;
    for (int k = 0; k < 200; k++) begin
      if (pc_tx_bus !== 1'b1) low_cnt++;
      tick();
    end
    check("t5_line_idle", low_cnt, 0);
    check("t5_busy_idle", busy, 0);
    got_q.delete();
    exp_q.delete();
    rx_on = 1'b1;

    // Test 6: drop counter saturation and clear
    b1_valid = 1'b1; b1_data = 8'h5A;
    repeat (310) tick();
    check("t6_level", fifo_level, 4);
    check("t6_sat", drop_count, 255);
    tick();
    check("t6_sat_hold", drop_count, 255);
    clear_drops = 1'b1;
    tick();
    check("t6_clear_vs_drop", drop_count, 0);
    clear_drops = 1'b0;
    tick();
    check("t6_count_after", drop_count, 1);
    b1_valid = 1'b0; clear_drops = 1'b1;
    tick();
    check("t6_clear", drop_count, 0);
    clear_drops = 1'b0;
    tick();
    check("t6_clear_hold", drop_count, 0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
